// File: rtl/lapido_boot_loader.sv
// Byte-stream program loader: frames SYNC/LEN/DATA/CHK images, writes 32-bit words
// to instruction memory and releases the core reset once the checksum verifies.
module lapido_boot_loader #(
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  input  logic                  restart,
  output logic                  imem_we,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  output logic [31:0]           imem_wdata,
  output logic                  core_rst,
  output logic                  load_done,
  output logic                  load_error,
  output logic [1:0]            err_code
);

  localparam int unsigned MAX_WORDS = 1 << ADDR_WIDTH;
  localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA,
    S_CHECK,
    S_DONE,
    S_ERROR
  } state_t;

  state_t          state, state_d;
  logic            accept;
  logic [7:0]      len_hi;
  logic [15:0]     len_q;
  logic [15:0]     len_in;
  logic [1:0]      byte_idx;
  logic [23:0]     word_sr;
  logic [7:0]      chk;
  logic [TW-1:0]   tmo_cnt;
  logic            tmo_active;
  logic            tmo_hit;
  logic            last_word;
  logic [1:0]      err_d;

  assign accept     = rx_valid && rx_ready;
  assign len_in     = {len_hi, rx_data};
  assign tmo_active = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                      (state == S_DATA)   || (state == S_CHECK);
  assign tmo_hit    = tmo_active && !accept && (tmo_cnt == TW'(TIMEOUT_CYCLES - 1));
  // imem_addr already holds the index of the word being assembled by its 4th byte
  assign last_word  = (byte_idx == 2'd3) &&
                      ((32'(imem_addr) + 32'd1) == 32'(len_q));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_d;
    end
  end

  always_comb begin
    state_d = state;
    err_d   = 2'b00;
    case (state)
      S_IDLE: begin
        if (accept && (rx_data == SYNC_BYTE)) state_d = S_LEN_HI;
      end
      S_LEN_HI: begin
        if (accept) state_d = S_LEN_LO;
      end
      S_LEN_LO: begin
        if (accept) begin
          if (32'(len_in) > MAX_WORDS) begin
            state_d = S_ERROR;
            err_d   = 2'b01;
          end else if (len_in == 16'd0) begin
            state_d = S_CHECK;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (accept && last_word) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (accept) begin
          if (rx_data == chk) begin
            state_d = S_DONE;
          end else begin
            state_d = S_ERROR;
            err_d   = 2'b10;
          end
        end
      end
      S_DONE, S_ERROR: begin
        if (restart) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (tmo_hit) begin
      state_d = S_ERROR;
      err_d   = 2'b11;
    end
  end

  always_comb begin
    rx_ready   = (state != S_DONE) && (state != S_ERROR);
    load_done  = (state == S_DONE);
    load_error = (state == S_ERROR);
    core_rst   = (state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      err_code   <= 2'b00;
      len_hi     <= '0;
      len_q      <= '0;
      byte_idx   <= '0;
      word_sr    <= '0;
      chk        <= '0;
      tmo_cnt    <= '0;
    end else begin
      imem_we <= 1'b0;
      // advance only while more words follow, so the address never passes MAX_WORDS-1
      if (imem_we && (state == S_DATA)) imem_addr <= imem_addr + ADDR_WIDTH'(1);

      if (!tmo_active || accept) begin
        tmo_cnt <= '0;
      end else begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end

      if ((state_d == S_ERROR) && (state != S_ERROR)) err_code <= err_d;

      case (state)
        S_LEN_HI: begin
          if (accept) begin
            len_hi <= rx_data;
            chk    <= rx_data;
          end
        end
        S_LEN_LO: begin
          if (accept) begin
            len_q     <= len_in;
            chk       <= chk ^ rx_data;
            imem_addr <= '0;
            byte_idx  <= '0;
          end
        end
        S_DATA: begin
          if (accept) begin
            word_sr  <= {word_sr[15:0], rx_data};
            chk      <= chk ^ rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              imem_we    <= 1'b1;
              imem_wdata <= {word_sr, rx_data};
            end
          end
        end
        S_DONE, S_ERROR: begin
          if (restart) begin
            err_code  <= 2'b00;
            imem_addr <= '0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lapido_boot_loader.sv
// Bench for lapido_boot_loader: fixed scenario table, hand sequences for timeout/reset,
// and random images checked against a stream-parsing reference model.
module tb_lapido_boot_loader;

  localparam int AW   = 4;
  localparam int MAXW = 16;
  localparam int TMO  = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          rx_ready;
  logic          restart;
  logic          imem_we;
  logic [AW-1:0] imem_addr;
  logic [31:0]   imem_wdata;
  logic          core_rst;
  logic          load_done;
  logic          load_error;
  logic [1:0]    err_code;

  always #5 clk = ~clk;

  lapido_boot_loader #(
    .ADDR_WIDTH     (AW),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_BYTE      (8'hA5)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .restart    (restart),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .core_rst   (core_rst),
    .load_done  (load_done),
    .load_error (load_error),
    .err_code   (err_code)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct {
    logic [127:0] stream;
    int           nbytes;
    bit           done;
    logic [1:0]   code;
    int           nwr;
    logic [31:0]  w0;
    logic [31:0]  w1;
  } vec_t;

  int         n_vec = 0;
  int         n_err = 0;
  wr_t        wr_q[$];
  wr_t        exp_wr[$];
  wr_t        mon_e;
  bit         exp_done;
  logic [1:0] exp_code;

  always @(negedge clk) begin
    if (rst && imem_we) begin
      mon_e.addr = imem_addr;
      mon_e.data = imem_wdata;
      wr_q.push_back(mon_e);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waits;
    repeat (gap) begin
      rx_data = 8'($urandom);
      @(negedge clk);
    end
    rx_data  = b;
    rx_valid = 1'b1;
    waits    = 0;
    while (!rx_ready && waits < 40) begin
      @(negedge clk);
      waits++;
    end
    check("rx_ready_wait", 64'(waits), 64'd0);
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_q(input logic [7:0] s[$], input int maxgap);
    foreach (s[i]) send_byte(s[i], (maxgap > 0) ? int'($urandom_range(0, maxgap)) : 0);
  endtask

  // Reference: locate SYNC, parse length, slice words, fold the checksum.
  task automatic predict(input logic [7:0] s[$]);
    int         p;
    int         n;
    logic [7:0] x;
    wr_t        e;
    p        = 0;
    exp_done = 1'b0;
    exp_code = 2'b00;
    exp_wr.delete();
    while (p < s.size() && s[p] != 8'hA5) p++;
    if (p + 2 >= s.size()) return;
    n = int'({s[p+1], s[p+2]});
    if (n > MAXW) begin
      exp_code = 2'b01;
      return;
    end
    x = s[p+1] ^ s[p+2];
    for (int w = 0; w < n; w++) begin
      e.addr = AW'(w);
      e.data = {s[p+3+4*w], s[p+4+4*w], s[p+5+4*w], s[p+6+4*w]};
      x = x ^ s[p+3+4*w] ^ s[p+4+4*w] ^ s[p+5+4*w] ^ s[p+6+4*w];
      exp_wr.push_back(e);
    end
    if (s[p+3+4*n] == x) exp_done = 1'b1;
    else exp_code = 2'b10;
  endtask

  task automatic check_status(input string name, input bit done, input logic [1:0] code);
    check({name, ".load_done"},  64'(load_done),  64'(done));
    check({name, ".load_error"}, 64'(load_error), 64'(code != 2'b00));
    check({name, ".err_code"},   64'(err_code),   64'(code));
    check({name, ".core_rst"},   64'(core_rst),   64'(done));
    check({name, ".rx_ready"},   64'(rx_ready),   64'(!done && code == 2'b00));
  endtask

  task automatic check_writes(input string name);
    check({name, ".nwrites"}, 64'(wr_q.size()), 64'(exp_wr.size()));
    if (wr_q.size() == exp_wr.size()) begin
      foreach (exp_wr[i]) begin
        check({name, ".waddr"}, 64'(wr_q[i].addr), 64'(exp_wr[i].addr));
        check({name, ".wdata"}, 64'(wr_q[i].data), 64'(exp_wr[i].data));
      end
    end
  endtask

  task automatic do_restart(input string name);
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check({name, ".rs.rx_ready"},   64'(rx_ready),   64'd1);
    check({name, ".rs.load_done"},  64'(load_done),  64'd0);
    check({name, ".rs.load_error"}, 64'(load_error), 64'd0);
    check({name, ".rs.err_code"},   64'(err_code),   64'd0);
    check({name, ".rs.core_rst"},   64'(core_rst),   64'd0);
    check({name, ".rs.imem_addr"},  64'(imem_addr),  64'd0);
  endtask

  task automatic check_reset_values(input string name);
    check({name, ".rx_ready"},   64'(rx_ready),   64'd1);
    check({name, ".imem_we"},    64'(imem_we),    64'd0);
    check({name, ".imem_addr"},  64'(imem_addr),  64'd0);
    check({name, ".imem_wdata"}, 64'(imem_wdata), 64'd0);
    check({name, ".core_rst"},   64'(core_rst),   64'd0);
    check({name, ".load_done"},  64'(load_done),  64'd0);
    check({name, ".load_error"}, 64'(load_error), 64'd0);
    check({name, ".err_code"},   64'(err_code),   64'd0);
  endtask

  vec_t       tbl[6];
  logic [7:0] s[$];

  initial begin
    logic [127:0] st;
    logic [7:0]   b;
    logic [7:0]   c;
    logic [7:0]   one;
    int           n;
    int           sel;

    tbl[0] = '{{96'hA50002112233_44AABBCCDD46, 32'h0}, 12, 1'b1, 2'b00, 2, 32'h11223344, 32'hAABBCCDD};
    tbl[1] = '{{96'hA50002112233_44AABBCCDD47, 32'h0}, 12, 1'b0, 2'b10, 2, 32'h11223344, 32'hAABBCCDD};
    tbl[2] = '{{24'hA50011, 104'h0},                    3, 1'b0, 2'b01, 0, 32'h0, 32'h0};
    tbl[3] = '{{24'h00FF5A, 96'hA50002112233_44AABBCCDD46, 8'h0}, 15, 1'b1, 2'b00, 2, 32'h11223344, 32'hAABBCCDD};
    tbl[4] = '{{32'hA5000000, 96'h0},                   4, 1'b1, 2'b00, 0, 32'h0, 32'h0};
    tbl[5] = '{{24'hA50100, 104'h0},                    3, 1'b0, 2'b01, 0, 32'h0, 32'h0};

    rst      = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    restart  = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values("por");
    rst = 1'b1;
    @(negedge clk);

    // restart is ignored outside DONE/ERROR
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
    check("restart_idle.rx_ready", 64'(rx_ready), 64'd1);

    for (int i = 0; i < 6; i++) begin
      wr_q.delete();
      st = tbl[i].stream;
      for (int j = 0; j < tbl[i].nbytes; j++) begin
        b = st[127-8*j -: 8];
        send_byte(b, 0);
      end
      check_status($sformatf("tbl%0d", i), tbl[i].done, tbl[i].code);
      check($sformatf("tbl%0d.nwrites", i), 64'(wr_q.size()), 64'(tbl[i].nwr));
      if (wr_q.size() == tbl[i].nwr && tbl[i].nwr == 2) begin
        check($sformatf("tbl%0d.w0addr", i), 64'(wr_q[0].addr), 64'd0);
        check($sformatf("tbl%0d.w0data", i), 64'(wr_q[0].data), 64'(tbl[i].w0));
        check($sformatf("tbl%0d.w1addr", i), 64'(wr_q[1].addr), 64'd1);
        check($sformatf("tbl%0d.w1data", i), 64'(wr_q[1].data), 64'(tbl[i].w1));
      end
      do_restart($sformatf("tbl%0d", i));
    end

    // timeout: 16 idle cycles after LEN_HI abort the load
    wr_q.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    repeat (15) @(negedge clk);
    check("tmo.before.load_error", 64'(load_error), 64'd0);
    @(negedge clk);
    check_status("tmo", 1'b0, 2'b11);
    check("tmo.nwrites", 64'(wr_q.size()), 64'd0);
    do_restart("tmo");

    // a byte on the 16th idle cycle wins over the timeout
    s = '{8'hA5, 8'h00, 8'h01, 8'h12, 8'h34, 8'h56, 8'h78, 8'h09};
    predict(s);
    wr_q.delete();
    send_byte(8'hA5, 0);
    send_byte(8'h00, 0);
    send_byte(8'h01, 15);
    check("keep.load_error", 64'(load_error), 64'd0);
    send_byte(8'h12, 15);
    send_byte(8'h34, 3);
    send_byte(8'h56, 0);
    send_byte(8'h78, 15);
    send_byte(8'h09, 15);
    check_status("keep", exp_done, exp_code);
    check_writes("keep");
    do_restart("keep");

    // asynchronous reset in the middle of DATA
    s = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB};
    send_q(s, 0);
    #2 rst = 1'b0;
    #1 check_reset_values("midrst");
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);

    s = '{8'hA5, 8'h00, 8'h02, 8'h11, 8'h22, 8'h33, 8'h44, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h46};
    predict(s);
    wr_q.delete();
    send_q(s, 2);
    check_status("reload1", exp_done, exp_code);
    check_writes("reload1");
    do_restart("reload1");

    s = '{8'hA5, 8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h23};
    predict(s);
    wr_q.delete();
    for (int j = 0; j < 5; j++) send_byte(s[j], 1);
    check("reload2.mid.core_rst", 64'(core_rst), 64'd0);
    for (int j = 5; j < 8; j++) send_byte(s[j], 1);
    check_status("reload2", exp_done, exp_code);
    check_writes("reload2");
    do_restart("reload2");

    one = 8'h01;
    for (int r = 0; r < 25; r++) begin
      s.delete();
      repeat ($urandom_range(0, 3)) begin
        do b = 8'($urandom); while (b == 8'hA5);
        s.push_back(b);
      end
      s.push_back(8'hA5);
      sel = int'($urandom_range(0, 9));
      if (sel < 2) n = int'($urandom_range(17, 400));
      else if (sel == 2) n = 16;
      else n = int'($urandom_range(0, 15));
      s.push_back(8'(n >> 8));
      s.push_back(8'(n));
      if (n <= MAXW) begin
        c = 8'(n >> 8) ^ 8'(n);
        for (int k = 0; k < 4 * n; k++) begin
          b = 8'($urandom);
          c = c ^ b;
          s.push_back(b);
        end
        if ($urandom_range(0, 3) == 0) c = c ^ (one << $urandom_range(0, 7));
        s.push_back(c);
      end
      predict(s);
      wr_q.delete();
      send_q(s, 4);
      check_status($sformatf("rnd%0d", r), exp_done, exp_code);
      check_writes($sformatf("rnd%0d", r));
      do_restart($sformatf("rnd%0d", r));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
